// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: instruction-fetch handshake and datapath strobes between the controller and its datapath
interface mips_multicycle_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             run;
  logic             imem_req;
  logic             imem_ack;
  logic [31:0]      instr;
  logic [PC_W-1:0]  pc;
  logic             ir_write;
  logic             reg_read;
  logic [1:0]       alu_op;
  logic [5:0]       func_code;
  logic [4:0]       write_reg;
  logic             reg_write;
  logic             pc_write;
  logic             busy;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  modport master (
    input  run, imem_ack, instr,
    output imem_req, pc, ir_write, reg_read, alu_op, func_code, write_reg,
           reg_write, pc_write, busy, illegal, retired
  );
  modport slave (
    output run, imem_ack, instr,
    input  imem_req, pc, ir_write, reg_read, alu_op, func_code, write_reg,
           reg_write, pc_write, busy, illegal, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: fetch/decode/exec/writeback sequencer for the R-type MIPS ALU datapath
module mips_multicycle_ctrl #(
  parameter int              PC_W     = 32,
  parameter int              PC_STEP  = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, TRAP} state_t;
  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);
  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             ir_write, nop, legal;
  assign ir_write = state_q == FETCH && bus.imem_ack;
  assign nop      = ir_q == '0;
  assign legal    = ir_q[31:26] == 6'd0 &&
                    ir_q[5:0] inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
  // unused encodings fall into TRAP so a corrupted state can never issue strobes
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.run ? FETCH : IDLE;
      FETCH:   state_d = bus.imem_ack ? DECODE : FETCH;
      DECODE:  state_d = legal ? EXEC : nop ? WB : TRAP;
      EXEC:    state_d = WB;
      WB:      state_d = bus.run ? FETCH : IDLE;
      default: state_d = TRAP;
    endcase
  end
  always_comb begin
    pc_d      = state_q == WB ? pc_q + STEP : pc_q;
    ir_d      = ir_write ? bus.instr : ir_q;
    retired_d = state_q == WB && ~&retired_q ? retired_q + CNT_W'(1) : retired_q;
    illegal_d = illegal_q | (state_d == TRAP);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end
  // rd==0 also covers the all-zero NOP word
  assign bus.imem_req  = state_q == FETCH;
  assign bus.ir_write  = ir_write;
  assign bus.reg_read  = state_q == DECODE;
  assign bus.alu_op    = state_q == EXEC ? 2'b10 : 2'b00;
  assign bus.reg_write = state_q == WB && ir_q[15:11] != 5'd0;
  assign bus.pc_write  = state_q == WB;
  assign bus.busy      = state_q != IDLE && state_q != TRAP;
  assign bus.illegal   = illegal_q;
  assign bus.pc        = pc_q;
  assign bus.func_code = ir_q[5:0];
  assign bus.write_reg = ir_q[15:11];
  assign bus.retired   = retired_q;
endmodule
